decode_stage: RTL and testbench

//  RV32I decode stage: consumes fetch's D-stage registers (InstrD/PCD/PCPlus4D).

---
 rtl/decode_stage.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage -- RV32I decode stage
//
// Takes the fetch stage's D registers (InstrD/PCD/PCPlus4D) and produces the
// execute stage's inputs. It decodes the control signals, extends the
// immediate, and reads a 32x32 register file that is written back from W.
// Everything is captured in the D/E pipeline register. The hazard unit drives
// StallE and FlushE.
//
// Optional feature: define WB_BYPASS_EN to forward ResultW onto the read ports
// when the W stage writes a register that D reads in the same cycle. Without
// it, a write is visible to reads one cycle later.
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   InstrD, PCD, PCPlus4D     D-stage instruction and PCs
//   StallE, FlushE            D/E register hold / bubble (see comment below)
//   RegWriteW, RDW, ResultW   register-file write port from W
//   Rs1D, Rs2D                combinational source indices for the hazard unit
//   RegWriteE .. IllegalE     registered control signals
//   RD1E, RD2E, ImmExtE       registered operands
//   RdE, Rs1E, Rs2E           registered register indices
//   PCE, PCPlus4E             registered PCs
// ============================================================================
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [2:0]      ALUControlE,
  output logic            IllegalE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4
  } immSel_t;

  // Everything the D/E register carries, packed so that reset and flush
  // can clear it with a single assignment.
  typedef struct packed {
    logic            regWrite;
    logic [1:0]      resultSrc;
    logic            memWrite;
    logic            jump;
    logic            branch;
    logic            aluSrc;
    logic [2:0]      aluControl;
    logic            illegal;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] immExt;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
  } deReg_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic [4:0]      rdD;

  logic            regWriteD;
  logic [1:0]      resultSrcD;
  logic            memWriteD;
  logic            jumpD;
  logic            branchD;
  logic            aluSrcD;
  logic [2:0]      aluControlD;
  logic            illegalD;
  immSel_t         immSel;
  logic [XLEN-1:0] immExtD;
  logic [XLEN-1:0] rd1D;
  logic [XLEN-1:0] rd2D;

  logic [XLEN-1:0] regs [NREGS];

  deReg_t deNext;
  deReg_t deQ;

  assign opcode   = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7b5 = InstrD[30];
  assign rdD      = InstrD[11:7];
  assign Rs1D     = InstrD[19:15];
  assign Rs2D     = InstrD[24:20];

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  always_comb begin
    regWriteD   = 1'b0;
    resultSrcD  = 2'b00;
    memWriteD   = 1'b0;
    jumpD       = 1'b0;
    branchD     = 1'b0;
    aluSrcD     = 1'b0;
    aluControlD = ALU_ADD;
    illegalD    = 1'b0;
    immSel      = IMM_NONE;
    case (opcode)
      OP_LW: begin
        regWriteD  = 1'b1;
        resultSrcD = 2'b01;
        aluSrcD    = 1'b1;
        immSel     = IMM_I;
      end
      OP_SW: begin
        memWriteD = 1'b1;
        aluSrcD   = 1'b1;
        immSel    = IMM_S;
      end
      OP_R, OP_IALU: begin
        regWriteD = 1'b1;
        aluSrcD   = (opcode == OP_IALU);
        immSel    = (opcode == OP_IALU) ? IMM_I : IMM_NONE;
        case (funct3)
          // funct7[5] selects sub only for R-type; for I-type it is imm bit 10.
          3'b000:  aluControlD = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControlD = ALU_SLT;
          3'b110:  aluControlD = ALU_OR;
          3'b111:  aluControlD = ALU_AND;
          default: begin
            // Unsupported ALU op: mark it and keep it from writing a register.
            regWriteD = 1'b0;
            aluSrcD   = 1'b0;
            immSel    = IMM_NONE;
            illegalD  = 1'b1;
          end
        endcase
      end
      OP_BEQ: begin
        branchD     = 1'b1;
        aluControlD = ALU_SUB;
        immSel      = IMM_B;
      end
      OP_JAL: begin
        regWriteD  = 1'b1;
        resultSrcD = 2'b10;
        jumpD      = 1'b1;
        immSel     = IMM_J;
      end
      // An all-zero word is a fetch bubble, not a fault.
      default: illegalD = (InstrD != 32'd0);
    endcase
  end

  // --------------------------------------------------------------------------
  // Immediate extension
  // --------------------------------------------------------------------------
  always_comb begin
    immExtD = '0;
    case (immSel)
      IMM_I: immExtD = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      IMM_S: immExtD = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B: immExtD = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                        InstrD[11:8], 1'b0};
      IMM_J: immExtD = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                        InstrD[30:21], 1'b0};
      default: immExtD = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Register file: x0 is never written and always reads zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (RegWriteW && RDW != 5'd0) begin
      regs[RDW] <= ResultW;
    end
  end

  always_comb begin
    rd1D = '0;
    rd2D = '0;
`ifdef WB_BYPASS_EN
    // A nonzero index that matches RDW implies RDW != 0.
    if (Rs1D != 5'd0) rd1D = (RegWriteW && RDW == Rs1D) ? ResultW : regs[Rs1D];
    if (Rs2D != 5'd0) rd2D = (RegWriteW && RDW == Rs2D) ? ResultW : regs[Rs2D];
`else
    if (Rs1D != 5'd0) rd1D = regs[Rs1D];
    if (Rs2D != 5'd0) rd2D = regs[Rs2D];
`endif
  end

  // --------------------------------------------------------------------------
  // D/E pipeline register.
  // FlushE loads an all-zero bubble. StallE holds the current contents.
  // FlushE wins over StallE, and with neither set the register loads every
  // edge. There is no valid/ready pairing: the hazard unit owns both signals.
  // --------------------------------------------------------------------------
  always_comb begin
    deNext.regWrite   = regWriteD;
    deNext.resultSrc  = resultSrcD;
    deNext.memWrite   = memWriteD;
    deNext.jump       = jumpD;
    deNext.branch     = branchD;
    deNext.aluSrc     = aluSrcD;
    deNext.aluControl = aluControlD;
    deNext.illegal    = illegalD;
    deNext.rd1        = rd1D;
    deNext.rd2        = rd2D;
    deNext.immExt     = immExtD;
    deNext.rd         = rdD;
    deNext.rs1        = Rs1D;
    deNext.rs2        = Rs2D;
    deNext.pc         = PCD;
    deNext.pcPlus4    = PCPlus4D;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deQ <= '0;
    end else if (FlushE) begin
      deQ <= '0;
    end else if (!StallE) begin
      deQ <= deNext;
    end
  end

  assign RegWriteE   = deQ.regWrite;
  assign ResultSrcE  = deQ.resultSrc;
  assign MemWriteE   = deQ.memWrite;
  assign JumpE       = deQ.jump;
  assign BranchE     = deQ.branch;
  assign ALUSrcE     = deQ.aluSrc;
  assign ALUControlE = deQ.aluControl;
  assign IllegalE    = deQ.illegal;
  assign RD1E        = deQ.rd1;
  assign RD2E        = deQ.rd2;
  assign ImmExtE     = deQ.immExt;
  assign RdE         = deQ.rd;
  assign Rs1E        = deQ.rs1;
  assign Rs2E        = deQ.rs2;
  assign PCE         = deQ.pc;
  assign PCPlus4E    = deQ.pcPlus4;

endmodule

// File: tb/tb_decode_stage.sv
// ============================================================================
// tb_decode_stage -- directed, table-driven bench for decode_stage.
// A table of instructions with hand-computed controls and immediates, then
// hand-written sequences: register file write/read, x0, stall/flush, and
// reset in the middle of a run.
// ============================================================================
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        StallE;
  logic        FlushE;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic [4:0]  Rs1D, Rs2D;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic        IllegalE;
  logic [31:0] RD1E, RD2E, ImmExtE;
  logic [4:0]  RdE, Rs1E, Rs2E;
  logic [31:0] PCE, PCPlus4E;

  // {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUSrc, ALUControl[2:0], Illegal}
  logic [10:0] ctlE;
  logic        anyE;
  assign ctlE = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
                 ALUControlE, IllegalE};
  assign anyE = |{ctlE, RD1E, RD2E, ImmExtE, RdE, Rs1E, Rs2E, PCE, PCPlus4E};

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .StallE(StallE), .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW),
    .ResultW(ResultW), .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE),
    .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .IllegalE(IllegalE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int nVec  = 0;
  int nFail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic stall, input logic flush);
    InstrD   = instr;
    PCD      = pc;
    PCPlus4D = pc + 32'd4;
    StallE   = stall;
    FlushE   = flush;
  endtask

  task automatic setWb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    RegWriteW = en;
    RDW       = rd;
    ResultW   = data;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [10:0] ctl;
    logic [31:0] imm;
    logic [4:0]  rd;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  localparam logic [10:0] CTL_ADDI = 11'b1_00_0_0_0_1_000_0;
  localparam logic [10:0] CTL_LW   = 11'b1_01_0_0_0_1_000_0;
  localparam logic [10:0] CTL_ILL  = 11'b0_00_0_0_0_0_000_1;

  initial begin
    vecs[0]  = '{32'h00500293, CTL_ADDI,                  32'h00000005, 5'd5};  // addi x5,x0,5
    vecs[1]  = '{32'h40000293, CTL_ADDI,                  32'h00000400, 5'd5};  // addi x5,x0,0x400 (bit30 set, still add)
    vecs[2]  = '{32'hFFF0E293, 11'b1_00_0_0_0_1_011_0,    32'hFFFFFFFF, 5'd5};  // ori x5,x1,-1
    vecs[3]  = '{32'h00812303, CTL_LW,                    32'h00000008, 5'd6};  // lw x6,8(x2)
    vecs[4]  = '{32'hFE612E23, 11'b0_00_1_0_0_1_000_0,    32'hFFFFFFFC, 5'd28}; // sw x6,-4(x2)
    vecs[5]  = '{32'h007380B3, 11'b1_00_0_0_0_0_000_0,    32'h00000000, 5'd1};  // add x1,x7,x7
    vecs[6]  = '{32'h402081B3, 11'b1_00_0_0_0_0_001_0,    32'h00000000, 5'd3};  // sub x3,x1,x2
    vecs[7]  = '{32'h0020F233, 11'b1_00_0_0_0_0_010_0,    32'h00000000, 5'd4};  // and x4,x1,x2
    vecs[8]  = '{32'h0020A433, 11'b1_00_0_0_0_0_101_0,    32'h00000000, 5'd8};  // slt x8,x1,x2
    vecs[9]  = '{32'hFE000CE3, 11'b0_00_0_0_1_0_001_0,    32'hFFFFFFF8, 5'd25}; // beq x0,x0,-8
    vecs[10] = '{32'h001000EF, 11'b1_10_0_1_0_0_000_0,    32'h00000800, 5'd1};  // jal x1,+2048
    vecs[11] = '{32'hFFDFF06F, 11'b1_10_0_1_0_0_000_0,    32'hFFFFFFFC, 5'd0};  // jal x0,-4
    vecs[12] = '{32'h0000007F, CTL_ILL,                   32'h00000000, 5'd0};  // unsupported opcode
    vecs[13] = '{32'h00000000, 11'b0,                     32'h00000000, 5'd0};  // fetch bubble
  end

  // ---------------- test ----------------
  initial begin
    logic [31:0] pc;
    logic [31:0] oldX7;
    logic [31:0] exp;

    rst = 1'b1;
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    setWb(1'b0, 5'd0, 32'd0);
    #2 rst = 1'b0;
    tick();
    tick();
    check("reset_all_zero", {63'd0, anyE}, 64'd0);
    rst = 1'b1;

    // Table: each instruction appears on E one clock later.
    for (int i = 0; i < NV; i++) begin
      pc = 32'h00001000 + 32'(i) * 32'd4;
      drive(vecs[i].instr, pc, 1'b0, 1'b0);
      #1;
      check($sformatf("v%0d_rs1d", i), {59'd0, Rs1D}, {59'd0, vecs[i].instr[19:15]});
      tick();
      check($sformatf("v%0d_ctl", i), {53'd0, ctlE}, {53'd0, vecs[i].ctl});
      check($sformatf("v%0d_imm", i), {32'd0, ImmExtE}, {32'd0, vecs[i].imm});
      check($sformatf("v%0d_rd", i), {59'd0, RdE}, {59'd0, vecs[i].rd});
      check($sformatf("v%0d_rs", i), {54'd0, Rs1E, Rs2E},
            {54'd0, vecs[i].instr[19:15], vecs[i].instr[24:20]});
      check($sformatf("v%0d_pc", i), {PCE, PCPlus4E}, {pc, pc + 32'd4});
    end

    // Unsupported ALU funct3 (sll) flags illegal.
    drive(32'h00209233, 32'h2000, 1'b0, 1'b0);
    tick();
    check("bad_funct3_illegal", {63'd0, IllegalE}, 64'd1);

    // Register file: same-cycle write and read of x7.
    oldX7 = 32'h11111111;
    drive(32'd0, 32'h2100, 1'b0, 1'b0);
    setWb(1'b1, 5'd7, oldX7);
    tick();
    drive(32'h007380B3, 32'h2104, 1'b0, 1'b0);  // add x1,x7,x7
    setWb(1'b1, 5'd7, 32'hDEADBEEF);
`ifdef WB_BYPASS_EN
    exp_q.push_back(32'hDEADBEEF);
`else
    exp_q.push_back(oldX7);
`endif
    exp_q.push_back(32'hDEADBEEF);
    tick();
    exp = exp_q.pop_front();
    check("samecyc_rd1", {32'd0, RD1E}, {32'd0, exp});
    check("samecyc_rd2", {32'd0, RD2E}, {32'd0, exp});
    setWb(1'b0, 5'd0, 32'd0);
    tick();
    exp = exp_q.pop_front();
    check("nextcyc_rd1", {32'd0, RD1E}, {32'd0, exp});
    check("nextcyc_rd2", {32'd0, RD2E}, {32'd0, exp});

    // x0 writes are dropped, including on the bypass path.
    drive(32'h000000B3, 32'h2200, 1'b0, 1'b0);  // add x1,x0,x0
    setWb(1'b1, 5'd0, 32'h12345678);
    tick();
    check("x0_samecyc", {RD1E, RD2E}, 64'd0);
    setWb(1'b0, 5'd0, 32'd0);
    tick();
    check("x0_after", {RD1E, RD2E}, 64'd0);

    // Stall holds for two clocks while InstrD changes.
    drive(32'h00500293, 32'h3000, 1'b0, 1'b0);  // addi x5,x0,5
    tick();
    drive(32'h00812303, 32'h3004, 1'b1, 1'b0);  // lw, stalled
    tick();
    check("stall1_ctl", {53'd0, ctlE}, {53'd0, CTL_ADDI});
    check("stall1_imm_pc", {ImmExtE, PCE}, {32'd5, 32'h3000});
    drive(32'hFE612E23, 32'h3008, 1'b1, 1'b0);  // sw, stalled
    tick();
    check("stall2_ctl", {53'd0, ctlE}, {53'd0, CTL_ADDI});
    check("stall2_rd_pc4", {27'd0, RdE, PCPlus4E}, {27'd0, 5'd5, 32'h3004});
    drive(32'h0000007F, 32'h300C, 1'b1, 1'b1);  // flush wins over stall
    tick();
    check("stall_flush_zero", {63'd0, anyE}, 64'd0);
    drive(32'h00500293, 32'h3010, 1'b0, 1'b1);  // plain flush
    tick();
    check("flush_zero", {63'd0, anyE}, 64'd0);
    drive(32'h00812303, 32'h3014, 1'b0, 1'b0);  // release
    tick();
    check("after_flush_ctl", {53'd0, ctlE}, {53'd0, CTL_LW});
    check("after_flush_pc", {32'd0, PCE}, {32'd0, 32'h3014});

    // Reset mid-run clears D/E asynchronously and clears the register file.
    drive(32'h00500293, 32'h4000, 1'b0, 1'b0);
    setWb(1'b1, 5'd5, 32'd5);
    tick();
    setWb(1'b0, 5'd0, 32'd0);
    drive(32'h005282B3, 32'h4004, 1'b0, 1'b0);  // add x5,x5,x5
    tick();
    check("pre_reset_x5", {32'd0, RD1E}, 64'd5);
    #2 rst = 1'b0;
    #1;
    check("async_reset_zero", {63'd0, anyE}, 64'd0);
    tick();
    rst = 1'b1;
    drive(32'h005282B3, 32'h4008, 1'b0, 1'b0);
    tick();
    check("post_reset_x5", {RD1E, RD2E}, 64'd0);
    check("post_reset_load", {53'd0, ctlE}, {53'd0, 11'b1_00_0_0_0_0_000_0});

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
